arg_max_stream: RTL and testbench
=================================

Name: arg_max_stream

Overview:
- Streaming argmax engine; the sequential, parametrised successor of the 10-input combinational comparator tree.
- Accepts a frame of up to N samples one per cycle over a valid/ready handshake.
- Tracks the running extreme value and its index, then presents {index, value, count} on a held output handshake.
- Supports signed/unsigned data, argmax/argmin mode and early frame termination. Sits between feature buffers and the classifier decision stage.

Parameters:
- WIDTH, 8, sample bit width (≥2)
- N, 10, maximum samples per frame (≥2)
- IDX_W, $clog2(N), index/count width (derived; not overridden)
- SIGNED, 0, 1 = compare as two's complement
- FIND_MIN, 0, 1 = argmin instead of argmax

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample present
- in_ready  out  1  block can accept a sample
- in_data  in  WIDTH  sample value
- in_last  in  1  sample is final of frame (qualified by in_valid & in_ready)
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- out_idx  out  IDX_W  index (0-based) of winning sample
- out_val  out  WIDTH  winning sample value
- out_cnt  out  IDX_W+1  samples in frame (1..N)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, in_ready=1, out_valid=0, out_idx=0, out_val=0, out_cnt=0, internal count=0. Reset mid-frame or while out_valid discards everything; no result is emitted.
- Accept event = in_valid & in_ready. Result output = out_valid & out_ready.
- in_ready = 1 in IDLE and ACC, 0 in DONE. in_ready does not depend combinationally on out_ready.
- IDLE: on accept, best_val<=in_data, best_idx<=0, count<=1. Go to ACC, or to DONE if in_last.
- ACC: on accept at position p=count, replace best only if strictly better: in_data > best_val (argmax) or < (argmin), using the signedness set by SIGNED. Ties keep the earlier index. count<=count+1. Go to DONE if in_last or p==N-1 (forced frame end at N samples even without in_last).
- No accept: state and registers hold. Bubbles are allowed anywhere in a frame.
- DONE entry: out_valid rises the cycle after the final accept, with out_idx/out_val/out_cnt registered. Latency from final accept to out_valid = 1 cycle.
- DONE: outputs stable while out_valid & !out_ready. On out_valid & out_ready, next cycle out_valid=0, state=IDLE, in_ready=1. A new frame's first sample can be accepted that cycle, so minimum frame-to-frame gap is 1 cycle.
- out_* values after handshake: hold their last values (don't-care for checking).
- Widths: the comparison is done on full WIDTH with no extension loss. Index counter never wraps because the forced end occurs at N-1.
- N=1 frames (in_last on the first sample) are legal: out_idx=0, out_cnt=1.

Decomposition:
- Package arg_max_pkg holds:
  - state_t enum {IDLE, ACC, DONE}
  - function better(a, b, signed_mode, min_mode) returning 1 when a strictly beats b.
- One sub-module: arg_cmp_param (WIDTH, SIGNED, FIND_MIN). Combinational strict-better flag, reused for later tree variants.
- Top holds the FSM, counter and registers.

Test Plan:
- Defaults; stream 3,7,2,9,9,1,0,4,5,8 with no in_last -> forced end at 10th sample. out_valid 1 cycle later; out_idx=3, out_val=9, out_cnt=10 (tie at index 4 ignored).
- SIGNED=1; stream 8'hF0, 8'h05, 8'h80 with in_last on third -> out_idx=1, out_val=8'h05, out_cnt=3. Same stream with SIGNED=0 -> out_idx=0, out_val=8'hF0.
- FIND_MIN=1; stream 6,2,2,9 with in_last -> out_idx=1, out_val=2, out_cnt=4.
- Backpressure: hold out_ready=0 for 5 cycles after result -> outputs stable, in_ready=0 throughout. Offered samples are not consumed. Release -> IDLE next cycle; next frame 1,0 + in_last -> out_idx=0, out_cnt=2.
- Random in_valid bubbles (50%) across a 10-sample frame -> result identical to the gap-free run.
- Assert rst mid-frame after 4 samples, then stream 5 + in_last -> out_idx=0, out_val=5, out_cnt=1; no stale result emitted.

Source files
------------

// File: rtl/arg_max_pkg.sv
// Shared types and the strict-better comparison used by the argmax/argmin engines.
// Operands arrive left-justified in CMP_W bits so one function covers every sample width.
package arg_max_pkg;

  localparam int CMP_W = 64;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  function automatic logic better(input logic [CMP_W-1:0] a,
                                  input logic [CMP_W-1:0] b,
                                  input logic             signed_mode,
                                  input logic             min_mode);
    logic gt;
    logic lt;
    if (signed_mode) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return min_mode ? lt : gt;
  endfunction

endpackage

// File: rtl/arg_cmp_param.sv
// Combinational flag: 1 when a strictly beats b (larger for argmax, smaller for argmin).
// Left-justifying keeps the sign bit at the top, so signed and unsigned compares stay exact.
module arg_cmp_param
  import arg_max_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SIGNED   = 0,
  parameter int FIND_MIN = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_better
);

  logic [CMP_W-1:0] a_j;
  logic [CMP_W-1:0] b_j;

  assign a_j      = CMP_W'(a) << (CMP_W - WIDTH);
  assign b_j      = CMP_W'(b) << (CMP_W - WIDTH);
  assign a_better = better(a_j, b_j, 1'(SIGNED), 1'(FIND_MIN));

endmodule

// File: rtl/arg_max_stream.sv
// Streaming argmax/argmin over frames of up to N samples; result held until out_ready.
// Result appears 1 cycle after the final accept; input is stalled while a result is pending.
module arg_max_stream
  import arg_max_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int N        = 10,
  parameter int SIGNED   = 0,
  parameter int FIND_MIN = 0,
  localparam int IDX_W   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] out_val,
  output logic [IDX_W:0]   out_cnt
);

  localparam logic [IDX_W:0] LAST_POS = (IDX_W+1)'(N - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] best_val_q, best_val_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic             accept;
  logic             in_better;

  arg_cmp_param #(
    .WIDTH    (WIDTH),
    .SIGNED   (SIGNED),
    .FIND_MIN (FIND_MIN)
  ) u_cmp (
    .a        (in_data),
    .b        (best_val_q),
    .a_better (in_better)
  );

  always_comb begin
    state_d    = state_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    cnt_d      = cnt_q;
    accept     = in_valid && (state_q != DONE);
    case (state_q)
      IDLE: begin
        if (accept) begin
          best_val_d = in_data;
          best_idx_d = '0;
          cnt_d      = (IDX_W+1)'(1);
          state_d    = in_last ? DONE : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          // Strict compare: ties keep the earlier index.
          if (in_better) begin
            best_val_d = in_data;
            best_idx_d = cnt_q[IDX_W-1:0];
          end
          cnt_d = cnt_q + (IDX_W+1)'(1);
          if (in_last || cnt_q == LAST_POS) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      best_val_q <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign out_idx   = best_idx_q;
  assign out_val   = best_val_q;
  assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_arg_max_stream.sv
// Directed bench: three engines (unsigned max, signed max, unsigned min) share one input stream.
module tb_arg_max_stream;

  localparam int W  = 8;
  localparam int N  = 10;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;

  logic          rdy_u, ov_u, rdy_s, ov_s, rdy_m, ov_m;
  logic [IW-1:0] idx_u, idx_s, idx_m;
  logic [W-1:0]  val_u, val_s, val_m;
  logic [IW:0]   cnt_u, cnt_s, cnt_m;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] s1 [10] = '{8'd3, 8'd7, 8'd2, 8'd9, 8'd9, 8'd1, 8'd0, 8'd4, 8'd5, 8'd8};
  logic [W-1:0] s2 [3]  = '{8'hF0, 8'h05, 8'h80};
  logic [W-1:0] s3 [4]  = '{8'd6, 8'd2, 8'd2, 8'd9};

  always #5 clk = ~clk;

  arg_max_stream #(.WIDTH(W), .N(N), .SIGNED(0), .FIND_MIN(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_u), .in_data(in_data),
    .in_last(in_last), .out_valid(ov_u), .out_ready(out_ready), .out_idx(idx_u),
    .out_val(val_u), .out_cnt(cnt_u));

  arg_max_stream #(.WIDTH(W), .N(N), .SIGNED(1), .FIND_MIN(0)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .in_data(in_data),
    .in_last(in_last), .out_valid(ov_s), .out_ready(out_ready), .out_idx(idx_s),
    .out_val(val_s), .out_cnt(cnt_s));

  arg_max_stream #(.WIDTH(W), .N(N), .SIGNED(0), .FIND_MIN(1)) u_min (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_m), .in_data(in_data),
    .in_last(in_last), .out_valid(ov_m), .out_ready(out_ready), .out_idx(idx_m),
    .out_val(val_m), .out_cnt(cnt_m));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one sample from a negedge and return just after the accepting posedge.
  task automatic send(input logic [W-1:0] d, input logic last, input logic bubble);
    int guard = 0;
    if (bubble) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!rdy_u && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check_eq("rdy_timeout", 32'd0, 32'd1);
    check_eq("ov_low_in_frame", 32'(ov_u), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_res(input string tag, input int idx, input int val, input int cnt,
                            input int s_idx, input int s_val, input int m_idx, input int m_val);
    check_eq({tag, "_ov"},    32'(ov_u), 32'd1);
    check_eq({tag, "_rdy"},   32'(rdy_u), 32'd0);
    check_eq({tag, "_idx"},   32'(idx_u), 32'(idx));
    check_eq({tag, "_val"},   32'(val_u), 32'(val));
    check_eq({tag, "_cnt"},   32'(cnt_u), 32'(cnt));
    check_eq({tag, "_s_idx"}, 32'(idx_s), 32'(s_idx));
    check_eq({tag, "_s_val"}, 32'(val_s), 32'(s_val));
    check_eq({tag, "_m_ov"},  32'(ov_m), 32'd1);
    check_eq({tag, "_m_idx"}, 32'(idx_m), 32'(m_idx));
    check_eq({tag, "_m_val"}, 32'(val_m), 32'(m_val));
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "_ov_drop"}, 32'(ov_u), 32'd0);
    check_eq({tag, "_rdy_back"}, 32'(rdy_u), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rdy", 32'(rdy_u), 32'd1);
    check_eq("rst_ov",  32'(ov_u),  32'd0);
    check_eq("rst_idx", 32'(idx_u), 32'd0);
    check_eq("rst_val", 32'(val_u), 32'd0);
    check_eq("rst_cnt", 32'(cnt_u), 32'd0);
    rst = 1'b0;

    // Forced end at N samples, tie at index 4 ignored.
    for (int i = 0; i < 10; i++) send(s1[i], 1'b0, 1'b0);
    expect_res("forced", 3, 9, 10, 3, 9, 6, 0);
    consume("forced");

    // Signed vs unsigned interpretation.
    for (int i = 0; i < 3; i++) send(s2[i], 1'(i == 2), 1'b0);
    expect_res("signed", 0, 8'hF0, 3, 1, 8'h05, 1, 8'h05);
    consume("signed");

    // Argmin with tie.
    for (int i = 0; i < 4; i++) send(s3[i], 1'(i == 3), 1'b0);
    expect_res("min", 3, 9, 4, 3, 9, 1, 2);
    consume("min");

    // Backpressure: result held, offered samples ignored.
    send(8'd7, 1'b0, 1'b0);
    send(8'd3, 1'b1, 1'b0);
    expect_res("bp", 0, 7, 2, 0, 7, 1, 3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'd200;
      in_last  = 1'b1;
      check_eq("bp_hold_ov",  32'(ov_u),  32'd1);
      check_eq("bp_hold_rdy", 32'(rdy_u), 32'd0);
      check_eq("bp_hold_idx", 32'(idx_u), 32'd0);
      check_eq("bp_hold_val", 32'(val_u), 32'd7);
      check_eq("bp_hold_cnt", 32'(cnt_u), 32'd2);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    consume("bp");
    send(8'd1, 1'b0, 1'b0);
    send(8'd0, 1'b1, 1'b0);
    expect_res("after_bp", 0, 1, 2, 0, 1, 1, 0);
    consume("after_bp");

    // Random bubbles give the same result as the gap-free run.
    for (int i = 0; i < 10; i++) send(s1[i], 1'b0, 1'($urandom_range(0, 1)));
    expect_res("bubbles", 3, 9, 10, 3, 9, 6, 0);
    consume("bubbles");

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 4; i++) send(s1[i], 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_ov",  32'(ov_u),  32'd0);
    check_eq("midrst_rdy", 32'(rdy_u), 32'd1);
    check_eq("midrst_cnt", 32'(cnt_u), 32'd0);
    send(8'd5, 1'b1, 1'b0);
    expect_res("midrst", 0, 5, 1, 0, 5, 0, 5);
    consume("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
